// File: rtl/code_lock_fsm_pkg.sv
// Shared types for the code lock: state encoding and a width helper for the window timer.
package code_lock_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ARMED   = 2'b00,
    OPEN    = 2'b01,
    LOCKOUT = 2'b10
  } lock_state_e;

  // Wide enough to hold max(a,b)-1; never narrower than one bit.
  function automatic int timer_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/code_lock_fsm_if.sv
// Verdict handshake and lock status bundle; attempt_cnt exists only when CODE_LOCK_AUDIT_EN is defined.
interface code_lock_fsm_if #(
  parameter int RUN_W  = 2,
  parameter int FAIL_W = 3
) ();
  import code_lock_pkg::*;

  logic               in_valid;
  logic               match;
  logic               in_ready;
  logic               unlocked;
  logic               locked_out;
  logic               alarm;
  logic [RUN_W-1:0]   run_cnt;
  logic [FAIL_W-1:0]  fail_cnt;
  logic [STATE_W-1:0] state;
`ifdef CODE_LOCK_AUDIT_EN
  logic [7:0]         attempt_cnt;
`endif

  modport master (
    output in_valid, match,
    input  in_ready, unlocked, locked_out, alarm, run_cnt, fail_cnt, state
`ifdef CODE_LOCK_AUDIT_EN
    , input attempt_cnt
`endif
  );

  modport slave (
    input  in_valid, match,
    output in_ready, unlocked, locked_out, alarm, run_cnt, fail_cnt, state
`ifdef CODE_LOCK_AUDIT_EN
    , output attempt_cnt
`endif
  );

endinterface

// File: rtl/code_lock_fsm_cyc_timer.sv
// Loadable down-counter that stops at zero; times both the OPEN and LOCKOUT windows.
module cyc_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] value_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= value_i;
    end else if (dec_i && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/code_lock_fsm.sv
// Code lock: turns per-symbol match verdicts into timed unlock / lockout decisions.
// Define CODE_LOCK_AUDIT_EN to add the saturating attempt_cnt output.
module code_lock_fsm
  import code_lock_pkg::*;
#(
  parameter int MATCH_RUN   = 3,
  parameter int MAX_FAIL    = 4,
  parameter int OPEN_CYC    = 8,
  parameter int LOCKOUT_CYC = 16
) (
  input logic            clk,
  input logic            rst,
  code_lock_fsm_if.slave bus
);

  localparam int RUN_W  = $clog2(MATCH_RUN + 1);
  localparam int FAIL_W = $clog2(MAX_FAIL + 1);
  localparam int TMR_W  = timer_width(OPEN_CYC, LOCKOUT_CYC);

  lock_state_e       state_q, state_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [FAIL_W-1:0] fail_q, fail_d;
  logic              unlocked_q, locked_out_q, alarm_q, alarm_d;
  logic              ready;
  logic              accept;
  logic              tmr_load, tmr_dec, tmr_zero;
  logic [TMR_W-1:0]  tmr_val;

  assign ready  = (state_q == ARMED);
  assign accept = bus.in_valid && ready;

  cyc_timer #(.WIDTH(TMR_W)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load_i  (tmr_load),
    .value_i (tmr_val),
    .dec_i   (tmr_dec),
    .zero_o  (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    run_d    = run_q;
    fail_d   = fail_q;
    alarm_d  = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_dec  = 1'b0;
    case (state_q)
      ARMED: begin
        if (accept) begin
          if (bus.match) begin
            if (run_q == RUN_W'(MATCH_RUN - 1)) begin
              state_d  = OPEN;
              run_d    = '0;
              fail_d   = '0;
              tmr_load = 1'b1;
              tmr_val  = TMR_W'(OPEN_CYC - 1);
            end else begin
              run_d = run_q + 1'b1;
            end
          end else begin
            run_d = '0;
            if (fail_q == FAIL_W'(MAX_FAIL - 1)) begin
              state_d  = LOCKOUT;
              fail_d   = '0;
              alarm_d  = 1'b1;
              tmr_load = 1'b1;
              tmr_val  = TMR_W'(LOCKOUT_CYC - 1);
            end else begin
              fail_d = fail_q + 1'b1;
            end
          end
        end
      end
      OPEN, LOCKOUT: begin
        if (tmr_zero) begin
          state_d = ARMED;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      default: begin
        // Unused encoding: fall back to a clean ARMED with the timer cleared.
        state_d  = ARMED;
        run_d    = '0;
        fail_d   = '0;
        tmr_load = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ARMED;
      run_q        <= '0;
      fail_q       <= '0;
      unlocked_q   <= 1'b0;
      locked_out_q <= 1'b0;
      alarm_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_q        <= run_d;
      fail_q       <= fail_d;
      unlocked_q   <= (state_d == OPEN);
      locked_out_q <= (state_d == LOCKOUT);
      alarm_q      <= alarm_d;
    end
  end

`ifdef CODE_LOCK_AUDIT_EN
  logic [7:0] attempt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      attempt_q <= '0;
    end else if (accept && (attempt_q != 8'hFF)) begin
      attempt_q <= attempt_q + 1'b1;
    end
  end

  assign bus.attempt_cnt = attempt_q;
`endif

  assign bus.in_ready   = ready;
  assign bus.unlocked   = unlocked_q;
  assign bus.locked_out = locked_out_q;
  assign bus.alarm      = alarm_q;
  assign bus.run_cnt    = run_q;
  assign bus.fail_cnt   = fail_q;
  assign bus.state      = state_q;

endmodule
